gap_sched: RTL and testbench
============================

# gap_sched

Channel scheduler for the global-average-pool stage of the MobileNet tail. It walks a channel-major feature map in on-chip RAM and streams each channel's points into the shared averaging unit. It then waits for that unit's result and hands each per-channel average downstream over a valid/ready port. It is the only driver of the averaging unit's input port and sequences one channel at a time, with no overlap.

## Interface

Parameters:
- DATA_WIDTH, 32, width of feature-map words and averages
- NUM_CHANNELS, 1024, channels per layer invocation
- POINTS_PER_CHANNEL, 49, spatial points per channel (7x7)
- ADDR_WIDTH, 16, feature-map RAM address width
- CH_WIDTH, $clog2(NUM_CHANNELS), channel index width

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; also resets the averaging unit externally
- start  in  1  one-cycle pulse, begins a layer; ignored while busy
- base_addr  in  ADDR_WIDTH  feature-map base; captured when start is accepted
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last channel's result is accepted
- err  out  1  sticky, set by pool_done outside WAIT_POOL; cleared on accepted start
- fm_rd_en  out  1  RAM read strobe
- fm_rd_addr  out  ADDR_WIDTH  RAM read address; data returns exactly 1 cycle later
- fm_rd_data  in  DATA_WIDTH  RAM read data
- pool_point_data  out  DATA_WIDTH  point to the averaging unit, equal to fm_rd_data combinationally
- pool_point_valid  out  1  fm_rd_en delayed one cycle (registered)
- pool_done  in  1  one-cycle pulse; pool_average is valid in the same cycle
- pool_average  in  DATA_WIDTH  channel average
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts when res_valid && res_ready
- res_data  out  DATA_WIDTH  captured average
- res_channel  out  CH_WIDTH  channel index of res_data

## Operation

- States: IDLE, FETCH, DRAIN, WAIT_POOL, OUTPUT, FINISH.
- **IDLE**: on start, capture base_addr into the address counter, clear the channel counter, point counter and err, then go to FETCH.
- **FETCH**:
  - fm_rd_en=1 every cycle; fm_rd_addr = running address, incremented by 1 per read, modulo 2^ADDR_WIDTH.
  - Addressing is channel-major: address = base + ch*POINTS_PER_CHANNEL + p, produced by increment only, with no multiply.
  - After POINTS_PER_CHANNEL reads, go to DRAIN.
- **DRAIN**: one cycle in which the last point's pool_point_valid is high. Then go to WAIT_POOL.
- **WAIT_POOL**: on pool_done, register pool_average into res_data and the channel counter into res_channel, then go to OUTPUT.
- **OUTPUT**:
  - res_valid=1; res_data and res_channel hold stable until the handshake.
  - On handshake, if ch==NUM_CHANNELS-1 go to FINISH; otherwise increment ch and go to FETCH.
  - The address counter continues from where it stopped and is not reloaded.
- **FINISH**: done=1 for one cycle, busy drops, then go to IDLE.
- pool_point_valid is never high outside the cycle following a read. Exactly POINTS_PER_CHANNEL valid points are sent per channel.
- pool_done in any state other than WAIT_POOL is ignored for data and sets err.
- start while busy is ignored, with no effect on counters or err.
- res_ready low stalls in OUTPUT indefinitely; no reads are issued while stalled.

## Timing

- Reset values: busy=0, done=0, err=0, fm_rd_en=0, fm_rd_addr=0, pool_point_valid=0, res_valid=0, res_data=0, res_channel=0, state=IDLE.
- A reset asserted mid-layer aborts in the following cycle. Partial channel data is discarded and no done pulse is produced.
- Per-channel sequence (start accepted at edge k):
  - fm_rd_en is high in cycles k+1 .. k+POINTS_PER_CHANNEL.
  - pool_point_valid is high in cycles k+2 .. k+POINTS_PER_CHANNEL+1.
  - WAIT_POOL begins at k+POINTS_PER_CHANNEL+2.
- res_valid rises the cycle after pool_done.
- After a handshake, the next channel's first read is in the next cycle. For the last channel, done is in the next cycle instead.
- Channel period = POINTS_PER_CHANNEL + 2 + pool latency + ready-wait cycles.

## Structure

- The shared package gap_pkg holds:
  - the state enum gap_state_t {IDLE, FETCH, DRAIN, WAIT_POOL, OUTPUT, FINISH};
  - the default constants GAP_POINTS=49 and GAP_CHANNELS=1024.
- One sub-module, gap_addr_gen, contains the point counter, channel counter and running address with load/increment/last-point/last-channel flags.
- The FSM and the result register stay in gap_sched.

## Test plan

- **Basic layer**: NUM_CHANNELS=4, base_addr=0x0100, RAM[a]=a, model pool returns the sum/49 three cycles after the 49th point, res_ready=1.
  - Reads cover 0x0100..0x01C3 contiguously.
  - Results are channel 0..3 = sums of 49 consecutive addresses divided by 49.
  - done is pulsed once; busy is high throughout.
- **Backpressure**: hold res_ready=0 for 20 cycles on channel 1 -> res_valid, res_data and res_channel are stable, fm_rd_en=0 during the stall, and channel 2's reads start the cycle after ready rises.
- **Address wrap**: base_addr=0xFFF0 -> fm_rd_addr runs 0xFFF0..0xFFFF, then 0x0000..0x0020 for channel 0.
- **Spurious/ignored inputs**:
  - pool_done pulsed during FETCH -> err=1, results unchanged, err clears on the next accepted start.
  - start pulsed mid-layer -> no effect.
- **Reset mid-operation**: assert reset during channel 2 WAIT_POOL -> all outputs at reset values the next cycle, no done. A fresh start then runs the full layer correctly from channel 0.

Source files
------------

// File: rtl/gap_pkg.sv
// Shared types and defaults for the global-average-pool channel scheduler.
package gap_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DRAIN     = 3'd2,
    WAIT_POOL = 3'd3,
    OUTPUT    = 3'd4,
    FINISH    = 3'd5
  } gap_state_t;

  localparam int GAP_POINTS   = 49;
  localparam int GAP_CHANNELS = 1024;

endpackage

// File: rtl/gap_addr_gen.sv
// Point/channel counters and the running feature-map read address.
// The address only ever increments, so channel-major order needs no multiplier.
module gap_addr_gen
  import gap_pkg::*;
#(
  parameter int NUM_CHANNELS       = GAP_CHANNELS,
  parameter int POINTS_PER_CHANNEL = GAP_POINTS,
  parameter int ADDR_WIDTH         = 16,
  parameter int CH_WIDTH           = $clog2(NUM_CHANNELS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  inc_i,
  input  logic                  next_ch_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [CH_WIDTH-1:0]   ch_o,
  output logic                  last_pt_o,
  output logic                  last_ch_o
);

  localparam int PT_WIDTH = (POINTS_PER_CHANNEL > 1) ? $clog2(POINTS_PER_CHANNEL) : 1;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PT_WIDTH-1:0]   pt_q, pt_d;
  logic [CH_WIDTH-1:0]   ch_q, ch_d;

  assign last_pt_o = (pt_q == PT_WIDTH'(POINTS_PER_CHANNEL - 1));
  assign last_ch_o = (ch_q == CH_WIDTH'(NUM_CHANNELS - 1));
  assign addr_o    = addr_q;
  assign ch_o      = ch_q;

  always_comb begin
    addr_d = addr_q;
    pt_d   = pt_q;
    ch_d   = ch_q;
    if (load_i) begin
      addr_d = base_i;
      pt_d   = '0;
      ch_d   = '0;
    end else begin
      // Address wraps naturally at 2^ADDR_WIDTH; point counter wraps per channel.
      if (inc_i) begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        pt_d   = last_pt_o ? '0 : pt_q + PT_WIDTH'(1);
      end
      if (next_ch_i) begin
        ch_d = ch_q + CH_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      pt_q   <= '0;
      ch_q   <= '0;
    end else begin
      addr_q <= addr_d;
      pt_q   <= pt_d;
      ch_q   <= ch_d;
    end
  end

endmodule

// File: rtl/gap_sched.sv
// Streams each channel of a channel-major feature map into the averaging unit,
// one channel at a time, and returns each channel average over a valid/ready port.
module gap_sched
  import gap_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int NUM_CHANNELS       = GAP_CHANNELS,
  parameter int POINTS_PER_CHANNEL = GAP_POINTS,
  parameter int ADDR_WIDTH         = 16,
  parameter int CH_WIDTH           = $clog2(NUM_CHANNELS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  fm_rd_en,
  output logic [ADDR_WIDTH-1:0] fm_rd_addr,
  input  logic [DATA_WIDTH-1:0] fm_rd_data,
  output logic [DATA_WIDTH-1:0] pool_point_data,
  output logic                  pool_point_valid,
  input  logic                  pool_done,
  input  logic [DATA_WIDTH-1:0] pool_average,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [CH_WIDTH-1:0]   res_channel,
  output logic [2:0]            dbg_state
);

  // Result port: a transfer happens on a rising edge where res_valid && res_ready;
  // once res_valid is raised, res_data/res_channel hold until that transfer.

  gap_state_t            state_q;
  logic                  busy_q, done_q, err_q, rd_en_q, pt_valid_q, res_valid_q;
  logic [DATA_WIDTH-1:0] res_data_q;
  logic [CH_WIDTH-1:0]   res_ch_q;

  logic                  ag_load, ag_inc, ag_next_ch, last_pt, last_ch;
  logic [ADDR_WIDTH-1:0] ag_addr;
  logic [CH_WIDTH-1:0]   ag_ch;

  assign ag_load    = (state_q == IDLE) && start;
  assign ag_inc     = (state_q == FETCH);
  assign ag_next_ch = (state_q == OUTPUT) && res_ready && !last_ch;

  gap_addr_gen #(
    .NUM_CHANNELS      (NUM_CHANNELS),
    .POINTS_PER_CHANNEL(POINTS_PER_CHANNEL),
    .ADDR_WIDTH        (ADDR_WIDTH),
    .CH_WIDTH          (CH_WIDTH)
  ) u_addr_gen (
    .clk_i    (clock),
    .rst_i    (reset),
    .load_i   (ag_load),
    .inc_i    (ag_inc),
    .next_ch_i(ag_next_ch),
    .base_i   (base_addr),
    .addr_o   (ag_addr),
    .ch_o     (ag_ch),
    .last_pt_o(last_pt),
    .last_ch_o(last_ch)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      pt_valid_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
    end else begin
      done_q     <= 1'b0;
      pt_valid_q <= rd_en_q;
      // A completion outside WAIT_POOL is never consumed, only flagged.
      if (pool_done && (state_q != WAIT_POOL)) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            err_q   <= 1'b0;
          end
        end
        FETCH: begin
          if (last_pt) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end
        end
        DRAIN: state_q <= WAIT_POOL;
        WAIT_POOL: begin
          if (pool_done) begin
            res_data_q  <= pool_average;
            res_ch_q    <= ag_ch;
            res_valid_q <= 1'b1;
            state_q     <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (last_ch) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= FETCH;
              rd_en_q <= 1'b1;
            end
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign fm_rd_en         = rd_en_q;
  assign fm_rd_addr       = ag_addr;
  assign pool_point_data  = fm_rd_data;
  assign pool_point_valid = pt_valid_q;
  assign res_valid        = res_valid_q;
  assign res_data         = res_data_q;
  assign res_channel      = res_ch_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_gap_sched.sv
// Bench for gap_sched: RAM and averaging-unit models, a read/result scoreboard,
// and one task per scenario.
module tb_gap_sched;
  import gap_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int NCH = 4;
  localparam int P   = 49;
  localparam int CW  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, err, fm_rd_en, pool_point_valid, res_valid;
  logic [AW-1:0] fm_rd_addr;
  logic [DW-1:0] fm_rd_data = '0;
  logic [DW-1:0] pool_point_data, res_data, pool_average;
  logic          pool_done;
  logic          res_ready = 1'b1;
  logic [CW-1:0] res_channel;
  logic [2:0]    dbg_state;

  int passed = 0;
  int total  = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] exp_ch_q[$];

  logic [DW-1:0] ram_seed = '0;
  int            pool_lat = 3;
  logic          model_done = 1'b0;
  logic          spur_done = 1'b0;
  logic [DW-1:0] model_avg = '0;

  assign pool_done    = model_done | spur_done;
  assign pool_average = spur_done ? 32'hDEAD_BEEF : model_avg;

  gap_sched #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(NCH), .POINTS_PER_CHANNEL(P), .ADDR_WIDTH(AW)
  ) dut (
    .clock(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .err(err),
    .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr), .fm_rd_data(fm_rd_data),
    .pool_point_data(pool_point_data), .pool_point_valid(pool_point_valid),
    .pool_done(pool_done), .pool_average(pool_average),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_channel(res_channel), .dbg_state(dbg_state)
  );

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return DW'(a) + ram_seed;
  endfunction

  // RAM model: one-cycle read latency
  always @(posedge clk) if (fm_rd_en) fm_rd_data <= ram_word(fm_rd_addr);

  // Averaging-unit model: sums P points, answers pool_lat cycles after the last one
  longint unsigned acc = 0;
  longint unsigned hold = 0;
  int cnt = 0;
  int timer = 0;
  always @(posedge clk) begin
    if (reset) begin
      acc <= 0; cnt <= 0; timer <= 0; model_done <= 1'b0;
    end else begin
      model_done <= 1'b0;
      if (pool_point_valid) begin
        if (cnt == P - 1) begin
          hold  <= (acc + 64'(pool_point_data)) / 64'(P);
          acc   <= 0;
          cnt   <= 0;
          timer <= pool_lat - 1;
        end else begin
          acc <= acc + 64'(pool_point_data);
          cnt <= cnt + 1;
        end
      end
      if (timer == 1) begin
        model_done <= 1'b1;
        model_avg  <= hold[DW-1:0];
        timer      <= 0;
      end else if (timer > 1) begin
        timer <= timer - 1;
      end
    end
  end

  // Reference: channel-major addresses and per-channel averages from plain arithmetic
  task automatic load_expect(input logic [AW-1:0] base);
    longint unsigned s;
    logic [AW-1:0] a;
    exp_addr_q.delete(); exp_q.delete(); exp_ch_q.delete();
    for (int c = 0; c < NCH; c++) begin
      s = 0;
      for (int p = 0; p < P; p++) begin
        a = base + AW'(c * P + p);
        exp_addr_q.push_back(a);
        s += 64'(ram_word(a));
      end
      exp_q.push_back(DW'(s / 64'(P)));
      exp_ch_q.push_back(CW'(c));
    end
  endtask

  // Scoreboard monitor
  logic          prev_rd_en = 1'b0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_ch;
  always @(negedge clk) begin
    total++;
    if (pool_point_valid !== prev_rd_en)
      $display("FAIL point_valid: got %b expected %b at %0t", pool_point_valid, prev_rd_en, $time);
    else passed++;
    prev_rd_en = fm_rd_en;
    if (fm_rd_en === 1'b1) begin
      total++;
      if (exp_addr_q.size() == 0) $display("FAIL rd_addr: got read of %h expected no read", fm_rd_addr);
      else begin
        m_addr = exp_addr_q.pop_front();
        if (fm_rd_addr !== m_addr) $display("FAIL rd_addr: got %h expected %h", fm_rd_addr, m_addr);
        else passed++;
      end
    end
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) $display("FAIL result: got ch %0d data %h expected no result", res_channel, res_data);
      else begin
        m_data = exp_q.pop_front();
        m_ch   = exp_ch_q.pop_front();
        if (res_data !== m_data || res_channel !== m_ch)
          $display("FAIL result: got ch %0d data %h expected ch %0d data %h", res_channel, res_data, m_ch, m_data);
        else passed++;
      end
    end
  end

  // driver tasks
  task automatic do_start(input logic [AW-1:0] base);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0; base_addr = AW'($urandom);
  endtask

  task automatic run_until_done(input int max_cyc, output int done_idx, output int dones,
                                output int busy_low, output int reads, output int first_rd,
                                output int first_wait, output bit timed_out);
    done_idx = 0; dones = 0; busy_low = 0; reads = 0; first_rd = 0; first_wait = 0; timed_out = 1'b1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (fm_rd_en === 1'b1) begin
        reads++;
        if (first_rd == 0) first_rd = i;
      end
      if (dbg_state === WAIT_POOL && first_wait == 0) first_wait = i;
      if (done === 1'b1) begin
        dones++; done_idx = i; timed_out = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_low++;
    end
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (fm_rd_en === 1'b1) reads++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, err, fm_rd_en, pool_point_valid, res_valid} !== 6'b0)
      $display("FAIL reset_flags: got %b expected 000000", {busy, done, err, fm_rd_en, pool_point_valid, res_valid});
    else passed++;
    total++;
    if (fm_rd_addr !== '0 || res_data !== '0 || res_channel !== '0)
      $display("FAIL reset_regs: got addr %h data %h ch %0d expected zeros", fm_rd_addr, res_data, res_channel);
    else passed++;
    total++;
    if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int di, dn, bl, rd, fr, fw; bit to;
    ram_seed = '0; pool_lat = 3; res_ready = 1'b1;
    load_expect(16'h0100);
    do_start(16'h0100);
    run_until_done(2000, di, dn, bl, rd, fr, fw, to);
    total++; if (to)  $display("FAIL basic_timeout: got no done expected done"); else passed++;
    total++; if (fr != 1) $display("FAIL basic_first_read: got cycle %0d expected 1", fr); else passed++;
    total++; if (fw != P + 2) $display("FAIL basic_wait_pool: got cycle %0d expected %0d", fw, P + 2); else passed++;
    total++; if (di != NCH * (P + 2 + pool_lat) + 1)
      $display("FAIL basic_done_cycle: got %0d expected %0d", di, NCH * (P + 2 + pool_lat) + 1); else passed++;
    total++; if (dn != 1) $display("FAIL basic_done_count: got %0d expected 1", dn); else passed++;
    total++; if (bl != 0) $display("FAIL basic_busy: got %0d low cycles expected 0", bl); else passed++;
    total++; if (rd != NCH * P) $display("FAIL basic_reads: got %0d expected %0d", rd, NCH * P); else passed++;
    total++; if (exp_q.size() != 0 || exp_addr_q.size() != 0)
      $display("FAIL basic_drained: got %0d results %0d reads left expected 0", exp_q.size(), exp_addr_q.size()); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL basic_idle_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] base;
    logic [DW-1:0] hd;
    logic [CW-1:0] hc;
    int unstable, rd_stall, wt;
    ram_seed = DW'($urandom_range(0, 32'h00FF_FFFF));
    pool_lat = $urandom_range(2, 6);
    base = AW'($urandom);
    res_ready = 1'b0;
    load_expect(base);
    do_start(base);
    for (int c = 0; c < NCH; c++) begin
      wt = 0;
      while (res_valid !== 1'b1 && wt < 300) begin @(negedge clk); wt++; end
      total++;
      if (res_valid !== 1'b1) begin
        $display("FAIL bp_wait_valid: got no res_valid for ch %0d expected res_valid", c);
        break;
      end else passed++;
      if (c == 1) begin
        hd = res_data; hc = res_channel; unstable = 0; rd_stall = 0;
        repeat (20) begin
          @(negedge clk);
          if (res_valid !== 1'b1 || res_data !== hd || res_channel !== hc) unstable++;
          if (fm_rd_en !== 1'b0 || pool_point_valid !== 1'b0) rd_stall++;
        end
        total++; if (unstable != 0) $display("FAIL bp_stable: got %0d changed cycles expected 0", unstable); else passed++;
        total++; if (rd_stall != 0) $display("FAIL bp_no_reads: got %0d read cycles expected 0", rd_stall); else passed++;
      end
      @(posedge clk); #1; res_ready = 1'b1;
      @(posedge clk); #1; res_ready = 1'b0;
      @(negedge clk);
      if (c < NCH - 1) begin
        total++;
        if (fm_rd_en !== 1'b1 || fm_rd_addr !== base + AW'((c + 1) * P))
          $display("FAIL bp_next_read: got en %b addr %h expected en 1 addr %h", fm_rd_en, fm_rd_addr, base + AW'((c + 1) * P));
        else passed++;
      end else begin
        total++; if (done !== 1'b1) $display("FAIL bp_done: got %b expected 1", done); else passed++;
      end
    end
    repeat (3) @(negedge clk);
    total++; if (exp_q.size() != 0 || exp_addr_q.size() != 0 || busy !== 1'b0)
      $display("FAIL bp_end: got %0d results %0d reads busy %b expected 0 0 0", exp_q.size(), exp_addr_q.size(), busy); else passed++;
    res_ready = 1'b1;
  endtask

  task automatic test_wrap();
    int di, dn, bl, rd, fr, fw; bit to;
    ram_seed = DW'($urandom_range(0, 32'h00FF_FFFF));
    pool_lat = $urandom_range(2, 6);
    load_expect(16'hFFF0);
    do_start(16'hFFF0);
    run_until_done(2000, di, dn, bl, rd, fr, fw, to);
    total++; if (to || dn != 1) $display("FAIL wrap_done: got timeout %b count %0d expected 0 1", to, dn); else passed++;
    total++; if (rd != NCH * P) $display("FAIL wrap_reads: got %0d expected %0d", rd, NCH * P); else passed++;
    total++; if (di != NCH * (P + 2 + pool_lat) + 1)
      $display("FAIL wrap_done_cycle: got %0d expected %0d", di, NCH * (P + 2 + pool_lat) + 1); else passed++;
    total++; if (exp_q.size() != 0 || exp_addr_q.size() != 0)
      $display("FAIL wrap_drained: got %0d results %0d reads left expected 0", exp_q.size(), exp_addr_q.size()); else passed++;
  endtask

  task automatic test_spurious();
    int di, dn, bl, rd, fr, fw; bit to;
    logic [AW-1:0] base;
    ram_seed = DW'($urandom_range(0, 32'h00FF_FFFF));
    pool_lat = $urandom_range(2, 6);
    base = AW'($urandom);
    load_expect(base);
    do_start(base);
    repeat (9) @(posedge clk);
    #1 spur_done = 1'b1;
    @(posedge clk); #1 spur_done = 1'b0;
    @(negedge clk);
    total++; if (err !== 1'b1) $display("FAIL spur_err_set: got %b expected 1", err); else passed++;
    @(posedge clk); #1; start = 1'b1; base_addr = ~base;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    total++; if (err !== 1'b1 || fm_rd_en !== 1'b1)
      $display("FAIL spur_start_ignored: got err %b rd_en %b expected 1 1", err, fm_rd_en); else passed++;
    run_until_done(2000, di, dn, bl, rd, fr, fw, to);
    total++; if (to || dn != 1) $display("FAIL spur_done: got timeout %b count %0d expected 0 1", to, dn); else passed++;
    total++; if (exp_q.size() != 0 || exp_addr_q.size() != 0 || err !== 1'b1)
      $display("FAIL spur_end: got %0d results %0d reads err %b expected 0 0 1", exp_q.size(), exp_addr_q.size(), err); else passed++;
    base = AW'($urandom);
    load_expect(base);
    do_start(base);
    @(negedge clk);
    total++; if (err !== 1'b0) $display("FAIL spur_err_clear: got %b expected 0", err); else passed++;
    run_until_done(2000, di, dn, bl, rd, fr, fw, to);
    total++; if (to || dn != 1 || exp_q.size() != 0)
      $display("FAIL spur_rerun: got timeout %b count %0d left %0d expected 0 1 0", to, dn, exp_q.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    int di, dn, bl, rd, fr, fw, wt, dn_abort, busy_abort; bit to;
    logic [AW-1:0] base;
    ram_seed = DW'($urandom_range(0, 32'h00FF_FFFF));
    pool_lat = $urandom_range(2, 6);
    base = AW'($urandom);
    load_expect(base);
    do_start(base);
    wt = 0;
    while (!(exp_q.size() == NCH - 2 && dbg_state === WAIT_POOL) && wt < 1000) begin
      @(negedge clk); wt++;
    end
    total++;
    if (wt >= 1000) $display("FAIL rst_reach_ch2: got no ch2 WAIT_POOL expected it within 1000 cycles");
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, err, fm_rd_en, pool_point_valid, res_valid} !== 6'b0)
      $display("FAIL rst_mid_flags: got %b expected 000000", {busy, done, err, fm_rd_en, pool_point_valid, res_valid});
    else passed++;
    total++;
    if (fm_rd_addr !== '0 || res_data !== '0 || res_channel !== '0 || dbg_state !== IDLE)
      $display("FAIL rst_mid_regs: got addr %h data %h ch %0d state %0d expected zeros", fm_rd_addr, res_data, res_channel, dbg_state);
    else passed++;
    reset = 1'b0;
    dn_abort = 0; busy_abort = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) dn_abort++;
      if (busy !== 1'b0) busy_abort++;
    end
    total++; if (dn_abort != 0 || busy_abort != 0)
      $display("FAIL rst_no_done: got %0d done %0d busy cycles expected 0 0", dn_abort, busy_abort); else passed++;
    base = AW'($urandom);
    load_expect(base);
    do_start(base);
    run_until_done(2000, di, dn, bl, rd, fr, fw, to);
    total++; if (to || dn != 1 || rd != NCH * P)
      $display("FAIL rst_rerun: got timeout %b done %0d reads %0d expected 0 1 %0d", to, dn, rd, NCH * P); else passed++;
    total++; if (exp_q.size() != 0 || exp_addr_q.size() != 0)
      $display("FAIL rst_rerun_drained: got %0d results %0d reads left expected 0", exp_q.size(), exp_addr_q.size()); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_spurious();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
